// File: rtl/game_flow_ctrl_pkg.sv
/******************************************************************************
 * Module   : game_pkg
 * Purpose  : State encoding and shared helpers for the game flow controller.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

package game_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_PLAYING = 3'd1;
  localparam state_t ST_PAUSED  = 3'd2;
  localparam state_t ST_WIN     = 3'd3;
  localparam state_t ST_LOSE    = 3'd4;

  function automatic logic is_end_state(input state_t s);
    return (s == ST_WIN) || (s == ST_LOSE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
/******************************************************************************
 * Module   : game_flow_ctrl_if
 * Purpose  : Buttons, game events and timer/status signals of the flow block.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

interface game_flow_ctrl_if;
  import game_pkg::*;

  logic       start_btn;
  logic       pause_btn;
  logic       player_dead;
  logic       level_cleared;
  logic [7:0] seconds_count;
  logic       timer_enable;
  logic       timer_reset;
  state_t     game_state;
  logic       game_over;
  logic       win;
  logic [7:0] round_count;

  modport master (
    output start_btn, pause_btn, player_dead, level_cleared, seconds_count,
    input  timer_enable, timer_reset, game_state, game_over, win, round_count
  );

  modport slave (
    input  start_btn, pause_btn, player_dead, level_cleared, seconds_count,
    output timer_enable, timer_reset, game_state, game_over, win, round_count
  );

endinterface

`default_nettype wire

// File: rtl/game_flow_ctrl_edge_detect.sv
/******************************************************************************
 * Module   : edge_detect
 * Purpose  : Rising-edge detector; history resets high so a held button is quiet.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module edge_detect (
  input  logic clk_game,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk_game) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
/******************************************************************************
 * Module   : game_flow_ctrl
 * Purpose  : Round state machine (idle/play/pause/win/lose) with Moore outputs.
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] TIME_LIMIT = 8'd99,
  parameter int         HOLD_TICKS = 180
) (
  input  logic            clk_game,
  input  logic            reset,
  game_flow_ctrl_if.slave bus
);

  localparam int                HOLD_W      = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_TICKS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_rounds;
  logic              w_start_edge;
  logic              w_pause_edge;

  edge_detect u_start_edge (
    .clk_game (clk_game),
    .reset    (reset),
    .i_btn    (bus.start_btn),
    .o_rise   (w_start_edge)
  );

  edge_detect u_pause_edge (
    .clk_game (clk_game),
    .reset    (reset),
    .i_btn    (bus.pause_btn),
    .o_rise   (w_pause_edge)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_state_nxt = ST_PLAYING;
      end
      ST_PLAYING: begin
        if (bus.player_dead)                       w_state_nxt = ST_LOSE;
        else if (bus.level_cleared)                w_state_nxt = ST_WIN;
        else if (bus.seconds_count >= TIME_LIMIT)  w_state_nxt = ST_LOSE;
        else if (w_pause_edge)                     w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (w_pause_edge || w_start_edge) w_state_nxt = ST_PLAYING;
      end
      ST_WIN, ST_LOSE: begin
        if (r_hold == c_hold_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Hold counter sits at zero outside WIN/LOSE, so it is already clear on entry.
  always_ff @(posedge clk_game) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_rounds <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (is_end_state(r_state)) begin
        if (r_hold != c_hold_last) r_hold <= r_hold + HOLD_W'(1);
      end else begin
        r_hold <= '0;
      end
      if ((r_state == ST_IDLE) && w_start_edge && (r_rounds != 8'hFF)) begin
        r_rounds <= r_rounds + 8'd1;
      end
    end
  end

  assign bus.timer_enable = (r_state == ST_PLAYING);
  assign bus.timer_reset  = (r_state == ST_IDLE);
  assign bus.game_over    = is_end_state(r_state);
  assign bus.win          = (r_state == ST_WIN);
  assign bus.game_state   = r_state;
  assign bus.round_count  = r_rounds;

endmodule

`default_nettype wire

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter TIME_LIMIT, default 8'd99, seconds value at which an active round is lost.
REQ-002 SHALL have parameter HOLD_TICKS, default 180, clock cycles spent in WIN/LOSE before returning to IDLE (3 s at 60 Hz).
REQ-003 SHALL have port clk_game  input  1  60 Hz game clock; the block uses only this clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start_btn  input  1  start/resume button, already synchronised to clk_game.
REQ-006 SHALL have port pause_btn  input  1  pause toggle button, already synchronised.
REQ-007 SHALL have port player_dead  input  1  level-sensitive loss event from game logic.
REQ-008 SHALL have port level_cleared  input  1  level-sensitive win event from game logic.
REQ-009 SHALL have port seconds_count  input  8  elapsed seconds from the downstream game timer.
REQ-010 SHALL have port timer_enable  output  1  drives the game timer's count enable.
REQ-011 SHALL have port timer_reset  output  1  drives the game timer's clear.
REQ-012 SHALL have port game_state  output  3  current state code.
REQ-013 SHALL have port game_over  output  1  high in WIN or LOSE.
REQ-014 SHALL have port win  output  1  high in WIN only.
REQ-015 SHALL have port round_count  output  8  number of rounds started, saturating.

Function
REQ-016 SHALL use state codes IDLE=0, PLAYING=1, PAUSED=2, WIN=3, LOSE=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-017 SHALL detect rising edges of start_btn and pause_btn: edge = btn & ~btn_prev, where btn_prev is registered each cycle.
REQ-018 SHALL update state on the clock edge that samples the detected edge or event (one-cycle latency from button high to new state).
REQ-019 SHALL decode all outputs from registered state only (Moore): timer_enable = (state==PLAYING), timer_reset = (state==IDLE), game_over = WIN|LOSE, win = (state==WIN).
REQ-020 IDLE: start edge -> PLAYING; round_count increments by 1 on that transition and saturates at 255.
REQ-021 PLAYING, priority order: player_dead -> LOSE; else level_cleared -> WIN; else seconds_count >= TIME_LIMIT -> LOSE; else pause edge -> PAUSED; else stay.
REQ-022 PLAYING SHALL ignore start edge.
REQ-023 PAUSED: pause edge or start edge -> PLAYING; player_dead, level_cleared and seconds_count SHALL be ignored.
REQ-024 WIN/LOSE: an internal hold counter SHALL clear on entry and increment each cycle; on the cycle it equals HOLD_TICKS-1 the state SHALL go to IDLE; all buttons and events SHALL be ignored.
REQ-025 Buttons held high SHALL produce exactly one edge; a button held through a state change SHALL NOT retrigger.
REQ-026 The hold counter SHALL be wide enough for HOLD_TICKS (derived via $clog2) and SHALL NOT wrap.

Reset
REQ-027 On reset, the block SHALL set state=IDLE, round_count=0, hold counter=0, and btn_prev registers=1 (so a button held through reset gives no edge).
REQ-028 Reset SHALL take priority over all events, including mid-round; the next-cycle outputs SHALL be timer_enable=0, timer_reset=1, game_over=0, win=0.

Structure
REQ-029 SHALL take the state encoding (typedef/localparams) and the 3-bit state width from shared package game_pkg.
REQ-030 SHALL instantiate one sub-module, edge_detect (1-bit synchronous rising-edge detector with reset value 1), once per button.

Verification
REQ-031 Reset, start_btn high 1 cycle -> next cycle state=1, timer_enable=1, timer_reset=0, round_count=1.
REQ-032 PLAYING, player_dead and level_cleared high in the same cycle -> state=4, win=0, game_over=1.
REQ-033 PLAYING, seconds_count driven to 99 -> LOSE next cycle; after exactly 180 cycles state=0, timer_reset=1.
REQ-034 PLAYING, pause edge -> PAUSED, timer_enable=0; player_dead pulsed -> stays 2; start edge -> back to 1.
REQ-035 start_btn held high for 10 cycles from IDLE -> exactly one transition, round_count=1; reset asserted while in PAUSED -> state=0, round_count=0.
REQ-036 256 start/clear rounds -> round_count holds at 255.
